// File: rtl/clk_div.sv
// Programmable clock divider: div_clk toggles every max_count+1 rising edges of clk.
// div_clk comes straight from a flop; it is never used as a clock inside this block.
module clk_div #(
    parameter int width = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] max_count,
    output logic             div_clk
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;
    logic             div_q;
    logic             div_d;
    logic             terminal;

    // Using >= rather than == means a lowered max_count ends the half-period
    // on the next edge instead of letting the counter wrap through 2^width.
    always_comb begin
        terminal = (count_q >= max_count);
        count_d  = count_q + width'(1);
        div_d    = div_q;
        if (terminal) begin
            count_d = '0;
            div_d   = ~div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    assign div_clk = div_q;

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: a 24-bit and a 4-bit instance are driven side by side
// and compared every cycle against an edge-counting reference model plus directed period checks.
module tb_clk_div;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] max_count;
    logic        div_clk;
    logic [3:0]  max_count4;
    logic        div_clk4;

    int assertions_count = 0;
    int failure_count    = 0;

    // Reference model: edges spent in the current half-period and the expected output level.
    int m_elapsed  = 0;
    int m_level    = 0;
    int m4_elapsed = 0;
    int m4_level   = 0;

    // Observed toggle bookkeeping (edges counted from the last reset release).
    int   edges        = 0;
    int   toggles      = 0;
    int   toggles4     = 0;
    int   first_toggle = 0;
    int   last_toggle  = 0;
    int   last_toggle4 = 0;
    int   exp_half     = 0;
    int   exp_half4    = 0;
    logic prev_div     = 1'b0;
    logic prev_div4    = 1'b0;

    clk_div #(.width(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .max_count (max_count),
        .div_clk   (div_clk)
    );

    clk_div #(.width(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .max_count (max_count4),
        .div_clk   (div_clk4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions_count++;
        if (observed !== expected) begin
            failure_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // A half-period lasts max+1 edges: the output flips once max edges have already elapsed.
    task automatic modelEdge(inout int elapsed, inout int level, input logic rst_v, input int max);
        if (!rst_v) begin
            elapsed = 0;
            level   = 0;
        end else if (elapsed >= max) begin
            elapsed = 0;
            level   = 1 - level;
        end else begin
            elapsed = elapsed + 1;
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input int max24, input int max4);
        rst        = rst_v;
        max_count  = max24[23:0];
        max_count4 = max4[3:0];
        @(posedge clk);
        modelEdge(m_elapsed, m_level, rst_v, max24);
        modelEdge(m4_elapsed, m4_level, rst_v, max4);
        #1;
        checkOutput("div_clk", {31'b0, div_clk}, m_level);
        checkOutput("count", {8'b0, dut.count_q}, m_elapsed);
        checkOutput("div_clk4", {31'b0, div_clk4}, m4_level);
        checkOutput("count4", {28'b0, dut4.count_q}, m4_elapsed);
        if (!rst_v) begin
            edges        = 0;
            last_toggle  = 0;
            last_toggle4 = 0;
        end else begin
            edges++;
            if (div_clk !== prev_div) begin
                toggles++;
                if (first_toggle == 0) first_toggle = edges;
                if (exp_half != 0 && last_toggle != 0)
                    checkOutput("half_period", edges - last_toggle, exp_half);
                last_toggle = edges;
            end
            if (div_clk4 !== prev_div4) begin
                toggles4++;
                if (exp_half4 != 0 && last_toggle4 != 0)
                    checkOutput("half_period4", edges - last_toggle4, exp_half4);
                last_toggle4 = edges;
            end
        end
        prev_div  = div_clk;
        prev_div4 = div_clk4;
    endtask

    task automatic startScenario(input int cycles, input int max24, input int max4);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, max24, max4);
        toggles      = 0;
        toggles4     = 0;
        first_toggle = 0;
    endtask

    initial begin
        rst        = 1'b0;
        max_count  = '0;
        max_count4 = '0;

        // 100 cycles at max_count 10 (and 15 on the 4-bit instance)
        startScenario(5, 10, 15);
        checkOutput("reset_div", {31'b0, div_clk}, 0);
        checkOutput("reset_count", {8'b0, dut.count_q}, 0);
        exp_half  = 11;
        exp_half4 = 16;
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 10, 15);
        checkOutput("toggles_max10", toggles, 9);
        checkOutput("first_toggle_max10", first_toggle, 11);
        checkOutput("toggles4_max15", toggles4, 6);
        exp_half4 = 0;

        // max_count 0 divides by two
        startScenario(2, 0, 15);
        exp_half = 1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0, 15);
        checkOutput("toggles_max0", toggles, 10);

        // max_count 3: four cycles high, four low
        startScenario(2, 3, 15);
        exp_half = 4;
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 3, 15);
        checkOutput("toggles_max3", toggles, 6);

        // Lower max_count from 10 to 2 while the counter sits at 7
        startScenario(2, 10, 15);
        exp_half = 0;
        for (int i = 0; i < 30 && m_elapsed != 7; i++) applyStimulus(1'b1, 10, 15);
        checkOutput("count_at_7", {8'b0, dut.count_q}, 7);
        toggles = 0;
        applyStimulus(1'b1, 2, 15);
        checkOutput("lower_max_toggle", toggles, 1);
        exp_half = 3;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 2, 15);
        checkOutput("toggles_after_lower", toggles, 5);

        // One-cycle reset in the middle of a half-period
        startScenario(2, 10, 15);
        exp_half = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10, 15);
        applyStimulus(1'b0, 10, 15);
        checkOutput("abort_div", {31'b0, div_clk}, 0);
        checkOutput("abort_count", {8'b0, dut.count_q}, 0);
        first_toggle = 0;
        toggles      = 0;
        exp_half     = 11;
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 10, 15);
        checkOutput("first_after_abort", first_toggle, 11);
        checkOutput("toggles_after_abort", toggles, 1);

        // Randomised max_count changes (raising, lowering, extremes) and sporadic resets
        startScenario(2, 5, 7);
        exp_half = 0;
        begin
            int   cur24 = 5;
            int   cur4  = 7;
            logic r;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) cur24 = ($urandom_range(0, 15) == 0) ? 24'hFFFFFF : $urandom_range(0, 20);
                if ($urandom_range(0, 3) == 0) cur4 = $urandom_range(0, 15);
                r = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
                applyStimulus(r, cur24, cur4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_count, failure_count);
        $finish;
    end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 Parameter: width, default 24, bit width of max_count and of the internal counter; legal range 1..32.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-004 max_count  input  width  half-period terminal count, unsigned; sampled every cycle, no handshake.
REQ-005 div_clk  output  1  divided clock, driven directly from a register (glitch-free), never from combinational logic.

Function
REQ-006 The block SHALL hold an unsigned counter of width bits plus the div_clk register.
REQ-007 On each clk rising edge out of reset with counter < max_count, the counter SHALL increment by 1 and div_clk SHALL hold.
REQ-008 On each clk rising edge out of reset with counter >= max_count, the counter SHALL load 0 and div_clk SHALL invert.
REQ-009 With max_count held constant, div_clk SHALL toggle every max_count+1 clk cycles, giving a period of 2*(max_count+1) cycles at 50% duty.
REQ-010 After reset release, the first div_clk toggle SHALL occur on the (max_count+1)th rising edge at which rst is sampled high.
REQ-011 max_count = 0 SHALL make div_clk toggle on every edge, i.e. clk/2.
REQ-012 max_count = all-ones SHALL be legal; the counter SHALL never overflow or wrap past max_count.
REQ-013 If max_count is lowered below the current counter value, the terminal condition of REQ-008 (>=) SHALL fire on the next edge, with no wrap through 2^width.
REQ-014 If max_count is raised mid-count, the running half-period SHALL extend to the new value with no extra toggle.
REQ-015 div_clk is a data-path signal: it SHALL NOT be used as a clock inside this block and carries no clock-buffer requirement.

Reset
REQ-016 While rst is sampled low, the counter SHALL be 0 and div_clk SHALL be 0 on the following edge.
REQ-017 Reset asserted mid-half-period SHALL abort the count; counting restarts from 0 with div_clk = 0 once rst returns high.
REQ-018 Outputs SHALL be defined (no X) from the first edge at which rst is sampled low.

Structure
REQ-019 No shared package is needed; width is the only parameter, and no typedefs or constants are exported.
REQ-020 The design SHALL be a single flat module with no sub-modules: one sequential process plus terminal-compare logic.

Verification
REQ-021 Reset 5 cycles with max_count = 10, then run 100 cycles -> exactly 9 div_clk toggles, the first on the 11th edge after release.
REQ-022 max_count = 0 -> div_clk toggles on every edge (period 2 cycles).
REQ-023 max_count = 3 -> div_clk high for 4 cycles, low for 4 cycles, repeating; counter sequence 0,1,2,3,0.
REQ-024 Counting with max_count = 10, lower max_count to 2 when the counter is 7 -> toggle on the next edge, then period 6 cycles.
REQ-025 Assert rst low for 1 cycle mid-half-period -> div_clk = 0 and counter = 0 on that edge; next toggle max_count+1 edges after release.
REQ-026 width = 4 with max_count = 15 -> period 32 cycles and no counter wrap; a self-checking reference model compares div_clk every cycle.
